// File: rtl/booth_mult_seq_if.sv
// Operand/product handshake bundle for booth_mult_seq.
// in_signed exists only when MULT_UNSIGNED_EN is defined.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
`ifdef MULT_UNSIGNED_EN
    logic               in_signed;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, a, b,
`ifdef MULT_UNSIGNED_EN
        output in_signed,
`endif
        output out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b,
`ifdef MULT_UNSIGNED_EN
        input  in_signed,
`endif
        input  out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock, valid/ready on both sides.
// Optional MULT_UNSIGNED_EN adds in_signed for unsigned operation (WIDTH+1 steps).
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_mult_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int PW    = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH+1:0] r_mplr;
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last;
    logic [PW-1:0]    r_product;

    logic             w_in_ready;
    logic             w_accept;
    logic [1:0]       w_pair;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_mcand_ext;
    logic [WIDTH+1:0] w_mplr_ext;
    logic [CNT_W-1:0] w_last;

`ifdef MULT_UNSIGNED_EN
    // Unsigned mode zero-extends both operands and needs one extra step for the top bit of b.
    assign w_mcand_ext = bus.in_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    assign w_mplr_ext  = {bus.in_signed ? bus.b[WIDTH-1] : 1'b0, bus.b, 1'b0};
    assign w_last      = bus.in_signed ? CNT_W'(WIDTH - 1) : CNT_W'(WIDTH);
`else
    assign w_mcand_ext = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
    assign w_mplr_ext  = {bus.b[WIDTH-1], bus.b, 1'b0};
    assign w_last      = CNT_W'(WIDTH - 1);
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready = 1'b1;
            S_DONE:  w_in_ready = bus.out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_pair   = r_mplr[r_cnt +: 2];

    always_comb begin
        w_acc_next = r_acc;
        case (w_pair)
            2'b01:   w_acc_next = r_acc + r_mcand;
            2'b10:   w_acc_next = r_acc - r_mcand;
            default: w_acc_next = r_acc;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_last    <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            // Covers both the idle accept and the back-to-back reload from DONE.
            r_mcand <= w_mcand_ext;
            r_mplr  <= w_mplr_ext;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_last  <= w_last;
            r_state <= S_BUSY;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == r_last) begin
                        r_product <= w_acc_next;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.product   = r_product;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=8): scoreboard on the output handshake,
// plus latency, backpressure, back-to-back and async-reset checks.
module tb_booth_mult_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(W)) bus();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_edge = 0;
    int rise_edge = 0;
    logic [2*W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
        if (sgn) return (2*W)'(int'($signed(a)) * int'($signed(b)));
        else     return (2*W)'(int'(a) * int'(b));
    endfunction

    // Scoreboard: compare each product on the cycle the consumer takes it.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
            else                   check("product", bus.product, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input bit hold);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
`ifdef MULT_UNSIGNED_EN
        bus.in_signed = sgn;
`endif
        for (int i = 0; i < 64; i++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                exp_q.push_back(model(a, b, sgn));
                acc_edge = cyc + 1;
                tick();
                break;
            end
            tick();
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                rise_edge = cyc;
                break;
            end
            tick();
        end
        if (!seen) check("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input string tag);
        send(a, b, sgn, 1'b0);
        wait_out();
        check({tag, "_latency"}, 32'(rise_edge - acc_edge), sgn ? 32'd8 : 32'd9);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
`ifdef MULT_UNSIGNED_EN
        bus.in_signed = 1'b1;
`endif
        repeat (3) tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_product", 32'(bus.product), 32'd0);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;

        // 7 * -3, one-cycle output pulse
        send(8'd7, 8'hFD, 1'b1, 1'b0);
        wait_out();
        check("t1_latency", 32'(rise_edge - acc_edge), 32'd8);
        check("t1_product", 32'(bus.product), 32'h0000_FFEB);
        tick();
        check("t1_pulse", 32'(bus.out_valid), 32'd0);

        run_op(8'h80, 8'h80, 1'b1, "neg_neg");
        run_op(8'h7F, 8'h80, 1'b1, "pos_neg");
        run_op(8'h00, 8'hFF, 1'b1, "zero");

        // Backpressure: result must hold for 5 cycles with in_ready low
        bus.out_ready = 1'b0;
        send(8'hF9, 8'h09, 1'b1, 1'b0);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_product", 32'(bus.product), 32'h0000_FFC1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release", 32'(bus.out_valid), 32'd0);

        // Back-to-back: second op accepted on the edge the first is consumed
        send(8'd3, 8'd4, 1'b1, 1'b1);
        a1 = acc_edge;
        send(8'hFB, 8'd6, 1'b1, 1'b0);
        check("b2b_spacing", 32'(acc_edge - a1), 32'd9);
        wait_out();
        check("b2b_latency", 32'(rise_edge - acc_edge), 32'd8);
        tick();

        // Async reset in the middle of 100*100
        send(8'd100, 8'd100, 1'b1, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_product", 32'(bus.product), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run_op(8'd2, 8'd3, 1'b1, "post_reset");

        for (int i = 0; i < 8; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'b1, "rand");
        end

`ifdef MULT_UNSIGNED_EN
        run_op(8'hFF, 8'hFF, 1'b0, "uns_ff");
        run_op(8'hFF, 8'hFF, 1'b1, "sgn_ff");
        run_op(8'd200, 8'd3, 1'b0, "uns_200x3");
        for (int i = 0; i < 4; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'b0, "uns_rand");
        end
`endif

        repeat (3) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
